// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared constants and enums for the TLK2711 transmit framer.
// Holds the 8b/10b code bytes, framed word constants, mode and frame-state
// enums, and a helper that folds reserved mode codes onto NORM.
package tlk2711_pkg;
    localparam logic [7:0]  K28_5   = 8'hBC;
    localparam logic [7:0]  D5_6    = 8'hC5;
    localparam logic [7:0]  D11_5   = 8'hAB;
    localparam logic [15:0] W_IDLE  = {K28_5, D5_6};
    localparam logic [15:0] W_HEAD  = {K28_5, D11_5};
    localparam logic [15:0] W_TAIL  = {D11_5, K28_5};
    localparam logic [15:0] W_KCODE = {K28_5, K28_5};

    typedef enum logic [2:0] {
        MODE_NORM  = 3'd0,
        MODE_LOOP  = 3'd1,
        MODE_KCODE = 3'd2,
        MODE_PRBS  = 3'd3
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HEAD, ST_TYPE, ST_END_FLAG, ST_COUNT,
        ST_LENGTH, ST_DATA, ST_CSUM, ST_TAIL
    } frame_state_e;

    function automatic mode_e decode_mode(input logic [2:0] m);
        return (m > 3'd3) ? MODE_NORM : mode_e'(m);
    endfunction
endpackage

// File: rtl/tlk2711_tx_framer_if.sv
// tlk2711_tx_framer_if: DMA beat stream feeding the framer.
//   i_dma_data/keep/valid/last : beat from the source (master)
//   o_dma_ready                : beat acceptance from the framer (slave)
interface tlk2711_tx_framer_if #(parameter int DMA_W = 64);
    logic [DMA_W-1:0]   i_dma_data;
    logic               i_dma_valid;
    logic [DMA_W/8-1:0] i_dma_keep;
    logic               i_dma_last;
    logic               o_dma_ready;

    modport master (output i_dma_data, i_dma_valid, i_dma_keep, i_dma_last,
                    input  o_dma_ready);
    modport slave  (input  i_dma_data, i_dma_valid, i_dma_keep, i_dma_last,
                    output o_dma_ready);
endinterface

// File: rtl/tlk2711_tx_gearbox.sv
// tlk2711_tx_gearbox: splits DMA beats into 16-bit lanes, lane 0 first.
//   beat_data/beat_keep : incoming beat (lane 0 bypassed when buffer empty)
//   take                : beat accepted this cycle
//   send                : a lane leaves this cycle
//   clr                 : drop whatever is buffered
//   full/final_lane     : buffer holds lanes / is on its last lane
//   word                : current lane, bytes with keep=0 forced to zero
module tlk2711_tx_gearbox #(
    parameter int DMA_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DMA_W-1:0]   beat_data,
    input  logic [DMA_W/8-1:0] beat_keep,
    input  logic               take,
    input  logic               send,
    input  logic               clr,
    output logic               full,
    output logic               final_lane,
    output logic [15:0]        word
);
    localparam int LANES = DMA_W / 16;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [DMA_W-1:0]   buf_data;
    logic [DMA_W/8-1:0] buf_keep;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        lane_d;
    logic [1:0]         lane_k;

    always_comb begin
        lane_d = full ? buf_data[idx*16 +: 16] : beat_data[15:0];
        lane_k = full ? buf_keep[idx*2 +: 2]   : beat_keep[1:0];
        word   = {lane_k[1] ? lane_d[15:8] : 8'h00, lane_k[0] ? lane_d[7:0] : 8'h00};
    end

    assign final_lane = full && (idx == IDX_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            full <= 1'b0;
            idx  <= '0;
        end else if (take) begin
            if (full) begin
                // old buffer's final lane leaves now; new beat starts at lane 0
                full <= 1'b1;
                idx  <= '0;
            end else begin
                // lane 0 went out on the bypass path this cycle
                full <= (LANES > 1);
                idx  <= IDX_W'(1);
            end
        end else if (send && full) begin
            if (final_lane) full <= 1'b0;
            else            idx  <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            buf_data <= beat_data;
            buf_keep <= beat_keep;
        end
    end
endmodule

// File: rtl/tlk2711_tx_framer.sv
// tlk2711_tx_framer: builds TLK2711 transmit frames from a DMA beat stream.
//   clk, rst_n (sync, active low); dma : beat stream (slave modport)
//   i_send_start/i_frame_type/i_frame_len/i_end_flag : frame request
//   i_mode_set/i_mode : mode load (NORM/LOOP/KCODE/PRBS)
//   o_txd/o_tk*/o_loopen/o_prbsen/o_enable/o_lckrefn/o_testen : PHY side, registered
//   o_busy, o_frame_cnt, o_underrun : status
// Optional: define TLK_TX_CHECKSUM_EN to insert a 16-bit sum word before TAIL.
module tlk2711_tx_framer
    import tlk2711_pkg::*;
#(
    parameter int DMA_W = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tlk2711_tx_framer_if.slave dma,
    input  logic             i_send_start,
    input  logic [15:0]      i_frame_type,
    input  logic [LEN_W-1:0] i_frame_len,
    input  logic             i_end_flag,
    input  logic             i_mode_set,
    input  logic [2:0]       i_mode,
    output logic [15:0]      o_txd,
    output logic             o_tkmsb,
    output logic             o_tklsb,
    output logic             o_loopen,
    output logic             o_prbsen,
    output logic             o_enable,
    output logic             o_lckrefn,
    output logic             o_testen,
    output logic             o_busy,
    output logic [LEN_W-1:0] o_frame_cnt,
    output logic             o_underrun
);
`ifdef TLK_TX_CHECKSUM_EN
    localparam frame_state_e ST_POST = ST_CSUM;
    logic [15:0] csum;
`else
    localparam frame_state_e ST_POST = ST_TAIL;
`endif

    frame_state_e     state, state_nxt;
    mode_e            mode, mode_nxt, pend_mode;
    logic             pend_vld;
    logic [15:0]      lat_type;
    logic [LEN_W-1:0] lat_len, wc;
    logic [LEN_W:0]   wc_inc;
    logic             lat_end, last_seen;
    logic             in_data, start_ok, take, send, pad, done;
    logic             gb_full, gb_final;
    logic [15:0]      gb_word, data_word, txd_d;
    logic             tkmsb_d, tklsb_d, urun_d;

    // Mode seen by this cycle's decisions: a strobe or pending load lands in IDLE.
    always_comb begin
        mode_nxt = mode;
        if (state == ST_IDLE) begin
            if (i_mode_set)    mode_nxt = decode_mode(i_mode);
            else if (pend_vld) mode_nxt = pend_mode;
        end
    end

    assign start_ok  = (state == ST_IDLE) && i_send_start &&
                       (mode_nxt == MODE_NORM || mode_nxt == MODE_LOOP);
    assign in_data   = (state == ST_DATA);
    assign wc_inc    = {1'b0, wc} + 1'b1;
    assign pad       = last_seen && !gb_full;
    // Never pull a beat the frame cannot use: stop once the last word is going out.
    assign dma.o_dma_ready = rst_n && in_data && !last_seen &&
                             (!gb_full || (gb_final && (wc_inc != {1'b0, lat_len})));
    assign take      = dma.i_dma_valid && dma.o_dma_ready;
    assign send      = in_data && (gb_full || pad || take);
    assign done      = send && (wc_inc == {1'b0, lat_len});
    assign data_word = pad ? 16'h0000 : gb_word;
    assign o_busy    = (state != ST_IDLE);

    tlk2711_tx_gearbox #(.DMA_W(DMA_W)) u_gearbox (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_data  (dma.i_dma_data),
        .beat_keep  (dma.i_dma_keep),
        .take       (take),
        .send       (send),
        .clr        (!in_data || done),
        .full       (gb_full),
        .final_lane (gb_final),
        .word       (gb_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_ok) state_nxt = ST_HEAD;
            ST_HEAD:     state_nxt = ST_TYPE;
            ST_TYPE:     state_nxt = ST_END_FLAG;
            ST_END_FLAG: state_nxt = ST_COUNT;
            ST_COUNT:    state_nxt = ST_LENGTH;
            ST_LENGTH:   state_nxt = (lat_len == '0) ? ST_POST : ST_DATA;
            ST_DATA:     if (done) state_nxt = ST_POST;
            ST_CSUM:     state_nxt = ST_TAIL;
            ST_TAIL:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        txd_d   = W_IDLE;
        tkmsb_d = 1'b1;
        tklsb_d = 1'b0;
        urun_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode_nxt == MODE_KCODE) begin
                    txd_d   = W_KCODE;
                    tklsb_d = 1'b1;
                end else if (mode_nxt == MODE_PRBS) begin
                    txd_d   = 16'h0000;
                    tkmsb_d = 1'b0;
                end
            end
            ST_HEAD:     txd_d = W_HEAD;
            ST_TYPE:     begin txd_d = lat_type;           tkmsb_d = 1'b0; end
            ST_END_FLAG: begin txd_d = {15'b0, lat_end};   tkmsb_d = 1'b0; end
            ST_COUNT:    begin txd_d = 16'(o_frame_cnt);   tkmsb_d = 1'b0; end
            ST_LENGTH:   begin txd_d = 16'(lat_len);       tkmsb_d = 1'b0; end
            ST_DATA: begin
                if (send) begin
                    txd_d   = data_word;
                    tkmsb_d = 1'b0;
                end else begin
                    urun_d  = 1'b1;   // starved: idle fill, not counted
                end
            end
            ST_CSUM: begin
`ifdef TLK_TX_CHECKSUM_EN
                txd_d = csum;
`else
                txd_d = 16'h0000;
`endif
                tkmsb_d = 1'b0;
            end
            ST_TAIL:     begin txd_d = W_TAIL; tkmsb_d = 1'b0; tklsb_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_NORM;
            pend_mode   <= MODE_NORM;
            pend_vld    <= 1'b0;
            lat_type    <= '0;
            lat_len     <= '0;
            lat_end     <= 1'b0;
            wc          <= '0;
            last_seen   <= 1'b0;
            o_frame_cnt <= '0;
            o_txd       <= '0;
            o_tkmsb     <= 1'b0;
            o_tklsb     <= 1'b0;
            o_loopen    <= 1'b0;
            o_prbsen    <= 1'b0;
            o_enable    <= 1'b0;
            o_lckrefn   <= 1'b0;
            o_testen    <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            mode  <= mode_nxt;
            if (state != ST_IDLE && i_mode_set) begin
                pend_vld  <= 1'b1;
                pend_mode <= decode_mode(i_mode);
            end else if (state == ST_IDLE) begin
                pend_vld  <= 1'b0;
            end
            if (start_ok) begin
                lat_type <= i_frame_type;
                lat_len  <= i_frame_len;
                lat_end  <= i_end_flag;
            end
            if (state == ST_IDLE) begin
                wc        <= '0;
                last_seen <= 1'b0;
            end else begin
                if (send) wc <= wc_inc[LEN_W-1:0];
                if (take && dma.i_dma_last) last_seen <= 1'b1;
            end
            if (state == ST_TAIL) o_frame_cnt <= o_frame_cnt + 1'b1;
            o_txd      <= txd_d;
            o_tkmsb    <= tkmsb_d;
            o_tklsb    <= tklsb_d;
            o_underrun <= urun_d;
            o_loopen   <= (mode_nxt == MODE_LOOP);
            o_prbsen   <= (mode_nxt == MODE_PRBS);
            o_enable   <= 1'b1;
            o_lckrefn  <= 1'b1;
            o_testen   <= 1'b0;
        end
    end

`ifdef TLK_TX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE) csum <= '0;
        else if (send)                  csum <= csum + data_word;
    end
`endif
endmodule

// File: doc/tlk2711_tx_framer.md
TLK2711_TX_FRAMER -- requirements
Module: tlk2711_tx_framer

Interface
REQ-001 SHALL have parameter DMA_W, default 64, DMA beat width; legal values 16/32/64/128.
REQ-002 SHALL have parameter LEN_W, default 16, width of frame-length and frame-count fields.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 i_dma_data  in  DMA_W, payload beat; i_dma_valid in 1; i_dma_keep in DMA_W/8; i_dma_last in 1; o_dma_ready out 1.
REQ-006 i_send_start  in  1  one-cycle frame request; i_frame_type in 16; i_frame_len in LEN_W, payload length in 16-bit words; i_end_flag in 1.
REQ-007 i_mode_set  in  1  mode load strobe; i_mode in 3: 0 NORM, 1 LOOP, 2 KCODE, 3 PRBS, 4-7 reserved (treated as NORM).
REQ-008 o_txd out 16; o_tkmsb, o_tklsb, o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen out 1 each; all registered.
REQ-009 o_busy out 1; o_frame_cnt out LEN_W, completed frames; o_underrun out 1, one-cycle pulse.

Function
REQ-010 Frame FSM SHALL have states IDLE, HEAD, TYPE, END_FLAG, COUNT, LENGTH, DATA, CSUM, TAIL; each non-DATA state lasts exactly one cycle.
REQ-011 IDLE: o_txd=16'hBCC5 (K28.5,D5.6), o_tkmsb=1, o_tklsb=0.
REQ-012 i_send_start in IDLE, mode NORM or LOOP: SHALL latch type/len/end_flag and go to HEAD next cycle; start while busy, or in KCODE/PRBS, is ignored.
REQ-013 Words: HEAD 16'hBCAB (K28.5,D11.5, tkmsb=1); TYPE = latched type; END_FLAG = {15'b0,end_flag}; COUNT = o_frame_cnt value at start; LENGTH = latched len (zero-extended); TAIL 16'hABBC (tklsb=1); data words have tk flags 0.
REQ-014 o_txd SHALL show a state's word the cycle after that state is entered (1-cycle output latency).
REQ-015 i_frame_len=0: LENGTH SHALL go directly to CSUM (or TAIL without checksum); no beats consumed.
REQ-016 DATA: each beat split into DMA_W/16 lanes, lane 0 (bits 15:0) sent first, one lane per cycle.
REQ-017 o_dma_ready SHALL be high only in DATA when the lane buffer is empty or its final lane is sent this cycle; beat accepted on valid&&ready.
REQ-018 Lane with keep bits 2'b00 SHALL be sent as 16'h0000 and still counted.
REQ-019 Once len words are sent, remaining lanes of the current beat SHALL be discarded.
REQ-020 i_dma_last before len reached: remaining words SHALL be sent as 16'h0000 without consuming beats.
REQ-021 Buffer empty and no valid beat in DATA: SHALL send 16'hBCC5 with tkmsb=1, not counted, and pulse o_underrun that cycle.
REQ-022 After TAIL: SHALL return to IDLE and increment o_frame_cnt, wrapping all-ones to 0.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 i_mode_set SHALL take effect next cycle if IDLE, else deferred until return to IDLE; a later strobe overrides a pending one.
REQ-025 NORM: o_loopen=0, o_prbsen=0. LOOP: o_loopen=1. KCODE: o_txd=16'hBCBC, both tk=1. PRBS: o_prbsen=1, o_txd=0, tk=0.
REQ-026 Outside reset: o_enable=1, o_lckrefn=1, o_testen=0.

Reset
REQ-027 rst_n=0 SHALL force: o_txd=0, all tk/control outputs 0, o_dma_ready=0, o_busy=0, o_frame_cnt=0, o_underrun=0, FSM IDLE, mode NORM, lane buffer empty, pending mode cleared.
REQ-028 Reset mid-frame SHALL abort the frame at once; the partially accepted beat is dropped.

Configuration
REQ-029 With TLK_TX_CHECKSUM_EN defined: CSUM state sends the 16-bit modulo-2^16 sum of all data words sent (pads included, underrun fill excluded).
REQ-030 Without TLK_TX_CHECKSUM_EN: CSUM state absent; LENGTH/DATA go directly to TAIL.

Structure
REQ-031 Package tlk2711_pkg SHALL hold K28_5, D5_6, D11_5, word constants, mode enum and frame-state enum.
REQ-032 Lane splitter SHALL be sub-module tlk2711_tx_gearbox (parameter DMA_W).

Verification
REQ-033 DMA_W=64, len=4, one beat 64'h0004_0003_0002_0001 -> data 0001,0002,0003,0004; with checksum CSUM=000A; o_frame_cnt 0->1.
REQ-034 len=0, type=16'h5A5A -> BCAB,5A5A,0000,cnt,0000,[0000],ABBC; o_dma_ready never high.
REQ-035 len=6, valid withheld 3 cycles after first beat -> three BCC5 fill words, o_underrun high 3 cycles, six data words.
REQ-036 i_mode_set with mode=2 mid-frame -> frame finishes unchanged; then o_txd=BCBC, tkmsb=tklsb=1.
REQ-037 rst_n low during DATA -> next cycle all outputs at reset values; frame restarted afterwards from HEAD, count 0.
REQ-038 o_frame_cnt preloaded to all-ones by 2^LEN_W-1 frames, one more frame -> wraps to 0.
